icache_mshr: RTL
================

# icache_mshr

Miss-status holding register file for the instruction cache. It accepts line misses from the I-cache lookup stage and coalesces duplicates. It issues `BUS_LOAD` requests on the I-cache side of the cache arbiter, tracks memory tags, and returns filled 64-bit lines to the I-cache data array. It sits directly upstream of the arbiter's `Icache2mem_*` inputs and consumes its `mem2Icache_*` outputs.

## Interface
- `NUM_MSHR`, default 4, number of outstanding line misses (2..8).
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `miss_valid`  in  1  I-cache lookup missed this cycle.
- `miss_addr`  in  `XLEN`  missing line address; bits [2:0] are ignored and treated as 0.
- `squash`  in  1  fetch redirect; discard all pending misses.
- `miss_ready`  out  1  a free entry exists; a miss is accepted iff `miss_valid && miss_ready && !squash`.
- `Icache2mem_command`  out  `BUS_COMMAND`  `BUS_LOAD` or `BUS_NONE`.
- `Icache2mem_addr`  out  `XLEN`  line address of the issuing entry; 0 when idle.
- `mem2Icache_response`  in  4  memory tag for the request presented this cycle; 0 means rejected.
- `mem2Icache_response_valid`  in  1  the arbiter routed memory to the I-cache this cycle.
- `mem2Icache_tag`  in  4  tag of the data on `mem2Icache_data`; 0 means no data.
- `mem2Icache_data`  in  64  returned line.
- `fill_valid`  out  1  registered; write `fill_data` to `fill_addr`.
- `fill_addr`  out  `XLEN`  line address of the fill (bits [2:0] = 0).
- `fill_data`  out  64  line data.

## Operation
- Each entry holds a state (INVALID, WAIT_ISSUE, WAIT_DATA), `addr[XLEN-1:3]`, `tag[3:0]` and a `discard` bit.
- **Allocate.** On an accepted miss:
  - If any valid entry holds the same line address and its `discard` bit is clear, nothing is allocated (coalesce).
  - Otherwise the lowest-index INVALID entry moves to WAIT_ISSUE with `discard`=0.
- **Issue.** The issuing entry is the lowest-index WAIT_ISSUE entry, selected from registered state.
  - While one exists, `Icache2mem_command`=`BUS_LOAD` and `Icache2mem_addr`={addr,3'b0}.
  - Both outputs are combinational from registered state.
  - The request is granted when `mem2Icache_response_valid && mem2Icache_response!=0` in the same cycle. The entry then moves to WAIT_DATA and latches `tag`=`mem2Icache_response`.
  - Without a grant the entry stays in WAIT_ISSUE and keeps driving the same request. This covers D-cache priority and memory refusal.
- **Data.** When `mem2Icache_tag!=0` matches the tag of a WAIT_DATA entry, that entry becomes INVALID.
  - If its `discard` bit is 0, the next cycle drives `fill_valid`=1, `fill_addr`, and `fill_data`=`mem2Icache_data` (as captured).
  - If its `discard` bit is 1, no fill is driven.
  - A nonmatching tag is ignored.
- **Squash.**
  - WAIT_ISSUE entries become INVALID immediately (next state).
  - WAIT_DATA entries set `discard`=1 and still wait for their tag, so memory tags are never leaked.
  - The miss presented in the same cycle is dropped.
- `miss_ready` = any entry INVALID in registered state; it is 0 while `reset` is high.

## Timing
- **Reset** (synchronous, active-high):
  - All entries go to INVALID with `discard`=0.
  - `fill_valid`=0, `fill_addr`=0, `fill_data`=0.
  - `Icache2mem_command`=`BUS_NONE`, `Icache2mem_addr`=0.
  - `miss_ready`=1 from the first cycle after reset deasserts.
  - Reset mid-transaction drops all tags; late tags that match nothing are ignored.
- **Latency:**
  - A miss accepted in cycle N is requested on the bus in cycle N+1 at the earliest.
  - A tag match in cycle M gives `fill_valid` in cycle M+1 for exactly one cycle.
- **Same-cycle events:**
  - Allocation and grant in the same cycle: the grant applies to the old issuing entry, and the new entry cannot issue until the next cycle.
  - Data return and a miss to the same line in the same cycle: the returning entry frees, and the miss allocates a new entry (no coalesce with a freeing entry).
  - Grant and squash in the same cycle: the entry enters WAIT_DATA with `discard`=1.
  - Tag match and squash in the same cycle: the entry frees and the fill is suppressed.
- **Full:** `miss_ready`=0. An entry freed in cycle N makes `miss_ready`=1 in cycle N+1.

## Test plan
- **Single miss.** Reset, then `miss_addr`=0x104 at cycle 2. Expect cycle 3: `BUS_LOAD`, `addr`=0x100. Grant with response=5. Tag 5 with data 0xDEADBEEF_CAFEF00D at cycle 10 gives `fill_valid`=1, `fill_addr`=0x100 and that data at cycle 11, then the entry frees.
- **Coalesce and full.** Misses to 0x100, 0x108, 0x100, 0x110 and 0x118 (`NUM_MSHR`=4). Expect only 4 entries (0x100, 0x108, 0x110, 0x118) and `miss_ready`=0 after the 0x118 allocation.
- **Arbiter stall.** Hold `mem2Icache_response_valid`=0 for 5 cycles, then grant. Expect `Icache2mem_command`/`addr` stable through the stall and exactly one grant recorded. A rejected grant (response=0) likewise leaves the entry in WAIT_ISSUE.
- **Out-of-order tags.** Entries granted tags 3 then 7; data returns for tag 7 before tag 3. Expect fills in return order, each with the correct address.
- **Squash.**
  - Setup: entry A in WAIT_DATA (tag 2) and entry B in WAIT_ISSUE; assert `squash`.
  - Expect B INVALID next cycle and `BUS_LOAD` deasserted.
  - Tag 2 returns later and frees A with no `fill_valid`.
  - A new miss to A's address during the discard allocates a separate entry.
- **Reset mid-flight.** Reset with 2 entries in WAIT_DATA, then return their tags. Expect no fill, `miss_ready`=1, and command `BUS_NONE`.

Source files
------------

// File: rtl/icache_mshr_if.sv
// I-cache MSHR bus bundle: lookup-side misses, arbiter request/response, and line fills.
// The MSHR side uses the master modport; the cache/arbiter side uses slave.
interface icache_mshr_if #(
    parameter int XLEN = 32
);
  logic            miss_valid;
  logic [XLEN-1:0] miss_addr;
  logic            squash;
  logic            miss_ready;
  logic [1:0]      Icache2mem_command;
  logic [XLEN-1:0] Icache2mem_addr;
  logic [3:0]      mem2Icache_response;
  logic            mem2Icache_response_valid;
  logic [3:0]      mem2Icache_tag;
  logic [63:0]     mem2Icache_data;
  logic            fill_valid;
  logic [XLEN-1:0] fill_addr;
  logic [63:0]     fill_data;

  modport master (
    input  miss_valid, miss_addr, squash,
    input  mem2Icache_response, mem2Icache_response_valid, mem2Icache_tag, mem2Icache_data,
    output miss_ready, Icache2mem_command, Icache2mem_addr,
    output fill_valid, fill_addr, fill_data
  );

  modport slave (
    output miss_valid, miss_addr, squash,
    output mem2Icache_response, mem2Icache_response_valid, mem2Icache_tag, mem2Icache_data,
    input  miss_ready, Icache2mem_command, Icache2mem_addr,
    input  fill_valid, fill_addr, fill_data
  );
endinterface

// File: rtl/icache_mshr.sv
// Miss-status holding registers for the I-cache: coalesces line misses, issues BUS_LOADs,
// tracks memory tags and returns filled lines. Squashed in-flight entries drain their tags silently.
module icache_mshr #(
    parameter int NUM_MSHR = 4,
    parameter int XLEN     = 32
) (
    input logic         clock,
    input logic         reset,
    icache_mshr_if.master bus
);
  localparam int IDX_W = $clog2(NUM_MSHR);
  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  typedef enum logic [1:0] {
    ST_INVALID,
    ST_WAIT_ISSUE,
    ST_WAIT_DATA
  } entry_state_t;

  entry_state_t    state_reg   [NUM_MSHR];
  entry_state_t    state_next  [NUM_MSHR];
  logic [XLEN-4:0] addr_reg    [NUM_MSHR];
  logic [XLEN-4:0] addr_next   [NUM_MSHR];
  logic [3:0]      tag_reg     [NUM_MSHR];
  logic [3:0]      tag_next    [NUM_MSHR];
  logic            discard_reg [NUM_MSHR];
  logic            discard_next[NUM_MSHR];

  logic            fill_valid_reg;
  logic [XLEN-1:0] fill_addr_reg;
  logic [63:0]     fill_data_reg;

  logic [NUM_MSHR-1:0] is_free, is_issue, tag_hit, dup_hit;
  logic [IDX_W-1:0]    free_idx, issue_idx, hit_idx;
  logic                any_free, issue_found, any_hit;
  logic                accept, allocate, grant, fill_fire;

  // A freeing entry never absorbs a new miss, so dup_hit excludes tag_hit.
  generate
    for (genvar gi = 0; gi < NUM_MSHR; gi++) begin : g_entry
      assign is_free[gi]  = (state_reg[gi] == ST_INVALID);
      assign is_issue[gi] = (state_reg[gi] == ST_WAIT_ISSUE);
      assign tag_hit[gi]  = (state_reg[gi] == ST_WAIT_DATA) && (bus.mem2Icache_tag != 4'd0) &&
                            (tag_reg[gi] == bus.mem2Icache_tag);
      assign dup_hit[gi]  = !is_free[gi] && !discard_reg[gi] && !tag_hit[gi] &&
                            (addr_reg[gi] == bus.miss_addr[XLEN-1:3]);
    end
  endgenerate

  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    hit_idx   = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (is_free[i])  free_idx  = IDX_W'(i);
      if (is_issue[i]) issue_idx = IDX_W'(i);
      if (tag_hit[i])  hit_idx   = IDX_W'(i);
    end
  end

  assign any_free    = |is_free;
  assign issue_found = |is_issue;
  assign any_hit     = |tag_hit;
  assign accept      = bus.miss_valid && bus.miss_ready && !bus.squash;
  assign allocate    = accept && !(|dup_hit);
  assign grant       = issue_found && bus.mem2Icache_response_valid &&
                       (bus.mem2Icache_response != 4'd0);
  assign fill_fire   = any_hit && !discard_reg[hit_idx] && !bus.squash;

  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      state_next[i]   = state_reg[i];
      addr_next[i]    = addr_reg[i];
      tag_next[i]     = tag_reg[i];
      discard_next[i] = discard_reg[i];
      case (state_reg[i])
        ST_INVALID: begin
          if (allocate && free_idx == IDX_W'(i)) begin
            state_next[i]   = ST_WAIT_ISSUE;
            addr_next[i]    = bus.miss_addr[XLEN-1:3];
            discard_next[i] = 1'b0;
          end
        end
        ST_WAIT_ISSUE: begin
          // A grant wins over a same-cycle squash: the tag must still be drained.
          if (grant && issue_idx == IDX_W'(i)) begin
            state_next[i]   = ST_WAIT_DATA;
            tag_next[i]     = bus.mem2Icache_response;
            discard_next[i] = bus.squash;
          end else if (bus.squash) begin
            state_next[i] = ST_INVALID;
          end
        end
        ST_WAIT_DATA: begin
          if (tag_hit[i]) begin
            state_next[i]   = ST_INVALID;
            discard_next[i] = 1'b0;
          end else if (bus.squash) begin
            discard_next[i] = 1'b1;
          end
        end
        default: state_next[i] = ST_INVALID;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_reg[i]   <= ST_INVALID;
        addr_reg[i]    <= '0;
        tag_reg[i]     <= '0;
        discard_reg[i] <= 1'b0;
      end
      fill_valid_reg <= 1'b0;
      fill_addr_reg  <= '0;
      fill_data_reg  <= '0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_reg[i]   <= state_next[i];
        addr_reg[i]    <= addr_next[i];
        tag_reg[i]     <= tag_next[i];
        discard_reg[i] <= discard_next[i];
      end
      fill_valid_reg <= fill_fire;
      if (fill_fire) begin
        fill_addr_reg <= {addr_reg[hit_idx], 3'b000};
        fill_data_reg <= bus.mem2Icache_data;
      end
    end
  end

  assign bus.miss_ready         = any_free && !reset;
  assign bus.Icache2mem_command = issue_found ? BUS_LOAD : BUS_NONE;
  assign bus.Icache2mem_addr    = issue_found ? {addr_reg[issue_idx], 3'b000} : '0;
  assign bus.fill_valid         = fill_valid_reg;
  assign bus.fill_addr          = fill_addr_reg;
  assign bus.fill_data          = fill_data_reg;
endmodule
